// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter
// Shares the core's single AXI read port between the I-cache and D-cache
// refill engines. One burst is owned end to end: the grant is taken in IDLE,
// the AR beat is issued from registered fields, and R beats are routed
// combinationally to the owner until the last beat has been accepted.
//
// state | meaning
// IDLE  | no burst owned; arbitrate, pulse x_arready and latch AR fields
// I_AR  | I-side AR beat presented, waiting for m_arready
// I_R   | I-side owns R channel until last-beat handshake
// D_AR  | D-side AR beat presented, waiting for m_arready
// D_R   | D-side owns R channel until last-beat handshake
module cache_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_arvalid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic [1:0]        i_arburst,
    output logic              i_arready,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_rresp,
    output logic              i_rvalid,
    output logic              i_rlast,
    input  logic              i_rready,

    input  logic              d_arvalid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    input  logic [2:0]        d_arsize,
    input  logic [1:0]        d_arburst,
    output logic              d_arready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_rresp,
    output logic              d_rvalid,
    output logic              d_rlast,
    input  logic              d_rready,

    output logic [3:0]        m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    output logic              m_rready
);

    typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R} state_t;

    state_t state, state_nxt;
    logic   last_grant;        // 0: I was granted last, 1: D was granted last
    logic   grant_i, grant_d;

    // Arbitration and next-state; a tie goes to the side not granted last.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_arvalid && (!d_arvalid || last_grant)) begin
                    grant_i   = 1'b1;
                    state_nxt = I_AR;
                end else if (d_arvalid) begin
                    grant_d   = 1'b1;
                    state_nxt = D_AR;
                end
            end
            I_AR: if (m_arready) state_nxt = I_R;
            I_R:  if (m_rvalid && i_rready && m_rlast) state_nxt = IDLE;
            D_AR: if (m_arready) state_nxt = D_R;
            D_R:  if (m_rvalid && d_rready && m_rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Held low while reset is asserted, whatever state the flops hold.
        i_arready = grant_i && resetn;
        d_arready = grant_d && resetn;
    end

    // State, fairness bit and the registered AR channel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            m_arvalid  <= 1'b0;
            m_arid     <= 4'b0000;
            m_araddr   <= '0;
            m_arlen    <= 8'd0;
            m_arsize   <= 3'b010;
            m_arburst  <= 2'b01;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                last_grant <= 1'b0;
                m_arvalid  <= 1'b1;
                m_arid     <= 4'b0000;
                m_araddr   <= i_araddr;
                m_arlen    <= i_arlen;
                m_arsize   <= i_arsize;
                m_arburst  <= i_arburst;
            end else if (grant_d) begin
                last_grant <= 1'b1;
                m_arvalid  <= 1'b1;
                m_arid     <= 4'b0001;
                m_araddr   <= d_araddr;
                m_arlen    <= d_arlen;
                m_arsize   <= d_arsize;
                m_arburst  <= d_arburst;
            end else if (m_arvalid && m_arready) begin
                m_arvalid  <= 1'b0;
            end
        end
    end

    // Zero-latency R routing to the current owner; the other side sees zeros.
    always_comb begin
        i_rdata  = '0;
        i_rresp  = 2'b00;
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        d_rdata  = '0;
        d_rresp  = 2'b00;
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
        m_rready = 1'b0;
        if (resetn) begin
            if (state == I_R) begin
                i_rdata  = m_rdata;
                i_rresp  = m_rresp;
                i_rvalid = m_rvalid;
                i_rlast  = m_rlast;
                m_rready = i_rready;
            end else if (state == D_R) begin
                d_rdata  = m_rdata;
                d_rresp  = m_rresp;
                d_rvalid = m_rvalid;
                d_rlast  = m_rlast;
                m_rready = d_rready;
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: grants, AR hold, R routing,
// back-pressure, fairness, mid-burst reset and error passthrough.
module tb_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_arvalid, d_arvalid;
    logic [31:0] i_araddr, d_araddr;
    logic [7:0]  i_arlen, d_arlen;
    logic [2:0]  i_arsize, d_arsize;
    logic [1:0]  i_arburst, d_arburst;
    logic        i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic [1:0]  i_rresp, d_rresp;
    logic        i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic        i_rready, d_rready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rlast, m_rready;

    int checks   = 0;
    int failures = 0;

    cache_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid),
        .i_rlast(i_rlast), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen),
        .d_arsize(d_arsize), .d_arburst(d_arburst), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid),
        .d_rlast(d_rlast), .d_rready(d_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_arsize = 3'b010; i_arburst = 2'b01;
        d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_arsize = 3'b010; d_arburst = 2'b01;
        i_rready = 0; d_rready = 0;
        m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0; m_rlast = 0;
    endtask

    task automatic do_reset;
        resetn = 0;
        clear_inputs();
        step();
        step();
        resetn = 1;
    endtask

    task automatic set_req(input bit s, input logic v, input logic [31:0] addr, input logic [7:0] len);
        if (!s) begin
            i_arvalid = v; i_araddr = addr; i_arlen = len;
        end else begin
            d_arvalid = v; d_araddr = addr; d_arlen = len;
        end
    endtask

    // Request(s) already driven in IDLE: side s must win this cycle.
    task automatic grant(input bit s);
        #1;
        check("arready_win", s ? d_arready : i_arready, 1);
        check("arready_lose", s ? i_arready : d_arready, 0);
        check("arvalid_pre_grant", m_arvalid, 0);
        step();
        if (!s) i_arvalid = 0; else d_arvalid = 0;
    endtask

    // AR phase: m_arready asserted after 'waits' cycles of holding.
    task automatic ar_phase(input bit s, input logic [31:0] addr, input logic [7:0] len, input int waits);
        for (int k = 0; k <= waits; k++) begin
            m_arready = (k == waits);
            #1;
            check("ar_valid", m_arvalid, 1);
            check("ar_id", m_arid, {3'b000, s});
            check("ar_addr", m_araddr, addr);
            check("ar_len", m_arlen, len);
            check("ar_i_arready", i_arready, 0);
            check("ar_d_arready", d_arready, 0);
            step();
        end
        m_arready = 0;
    endtask

    // R phase: beats stall_lo..stall_hi get one cycle of requester back-pressure first.
    task automatic r_beats(input bit s, input int n, input logic [1:0] resp,
                           input int stall_lo, input int stall_hi, input logic [31:0] addr);
        logic [31:0] dat;
        for (int b = 0; b < n; b++) begin
            dat = 32'hA500_0000 | (32'(s) << 16) | 32'(b);
            m_rvalid = 1; m_rdata = dat; m_rlast = (b == n - 1); m_rresp = resp;
            if (b >= stall_lo && b <= stall_hi) begin
                if (!s) i_rready = 0; else d_rready = 0;
                #1;
                check("bp_rready", m_rready, 0);
                check("bp_rvalid", s ? d_rvalid : i_rvalid, 1);
                check("bp_rdata", s ? d_rdata : i_rdata, dat);
                check("bp_rlast", s ? d_rlast : i_rlast, (b == n - 1));
                step();
            end
            if (!s) i_rready = 1; else d_rready = 1;
            #1;
            check("r_valid", s ? d_rvalid : i_rvalid, 1);
            check("r_data", s ? d_rdata : i_rdata, dat);
            check("r_resp", s ? d_rresp : i_rresp, resp);
            check("r_last", s ? d_rlast : i_rlast, (b == n - 1));
            check("r_mready", m_rready, 1);
            check("r_other_valid", s ? i_rvalid : d_rvalid, 0);
            check("r_other_data", s ? i_rdata : d_rdata, 0);
            check("r_other_last", s ? i_rlast : d_rlast, 0);
            check("r_arvalid", m_arvalid, 0);
            check("r_araddr_hold", m_araddr, addr);
            check("r_arready_i", i_arready, 0);
            check("r_arready_d", d_arready, 0);
            step();
        end
        m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rdata = 0;
        i_rready = 0; d_rready = 0;
    endtask

    initial begin
        // Reset values with active inputs that must be ignored.
        resetn = 0;
        clear_inputs();
        i_arvalid = 1; d_arvalid = 1; m_rvalid = 1; m_rlast = 1; m_rdata = 32'hDEAD_BEEF;
        i_rready = 1; d_rready = 1;
        step();
        step();
        check("rst_i_arready", i_arready, 0);
        check("rst_d_arready", d_arready, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_mready", m_rready, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_arlen", m_arlen, 0);
        check("rst_arsize", m_arsize, 3'b010);
        check("rst_arburst", m_arburst, 2'b01);
        check("rst_arid", m_arid, 0);
        clear_inputs();
        resetn = 1;
        step();

        // Single I burst, 8 beats, AR accepted after 2 wait cycles.
        set_req(0, 1, 32'h1FC0_0000, 8'd7);
        grant(0);
        ar_phase(0, 32'h1FC0_0000, 8'd7, 2);
        r_beats(0, 8, 2'b00, 99, 99, 32'h1FC0_0000);

        // Tie from reset: I first, D after, then alternating; D waits during I burst.
        do_reset();
        set_req(0, 1, 32'h0000_1000, 8'd1);
        set_req(1, 1, 32'h0000_2000, 8'd1);
        grant(0);
        ar_phase(0, 32'h0000_1000, 8'd1, 0);
        r_beats(0, 2, 2'b00, 99, 99, 32'h0000_1000);
        set_req(0, 1, 32'h0000_1100, 8'd0);
        grant(1);
        ar_phase(1, 32'h0000_2000, 8'd1, 0);
        r_beats(1, 2, 2'b00, 99, 99, 32'h0000_2000);
        set_req(1, 1, 32'h0000_2100, 8'd0);
        grant(0);
        ar_phase(0, 32'h0000_1100, 8'd0, 0);
        r_beats(0, 1, 2'b00, 99, 99, 32'h0000_1100);
        grant(1);
        ar_phase(1, 32'h0000_2100, 8'd0, 0);
        r_beats(1, 1, 2'b00, 99, 99, 32'h0000_2100);

        // Back-pressure on beats 3 and 4 of a len-3 D burst.
        set_req(1, 1, 32'h0000_3000, 8'd3);
        grant(1);
        ar_phase(1, 32'h0000_3000, 8'd3, 1);
        r_beats(1, 4, 2'b00, 2, 3, 32'h0000_3000);

        // Reset asserted during D_R beat 2.
        set_req(1, 1, 32'h0000_4000, 8'd3);
        grant(1);
        ar_phase(1, 32'h0000_4000, 8'd3, 0);
        m_rvalid = 1; m_rdata = 32'h1111_0001; m_rlast = 0; d_rready = 1;
        #1;
        check("mid_beat1_valid", d_rvalid, 1);
        step();
        m_rdata = 32'h1111_0002;
        resetn = 0;
        #1;
        check("mid_rst_rvalid", d_rvalid, 0);
        check("mid_rst_rdata", d_rdata, 0);
        check("mid_rst_mready", m_rready, 0);
        step();
        resetn = 1;
        clear_inputs();
        #1;
        check("post_rst_arvalid", m_arvalid, 0);
        check("post_rst_araddr", m_araddr, 0);
        check("post_rst_arlen", m_arlen, 0);
        check("post_rst_arid", m_arid, 0);
        check("post_rst_arsize", m_arsize, 3'b010);
        check("post_rst_drvalid", d_rvalid, 0);
        set_req(0, 1, 32'h0000_5000, 8'd0);
        set_req(1, 1, 32'h0000_6000, 8'd0);
        grant(0);
        ar_phase(0, 32'h0000_5000, 8'd0, 0);
        r_beats(0, 1, 2'b00, 99, 99, 32'h0000_5000);

        // SLVERR on a single-beat D read, then a normal return to IDLE.
        grant(1);
        ar_phase(1, 32'h0000_6000, 8'd0, 0);
        r_beats(1, 1, 2'b10, 99, 99, 32'h0000_6000);
        set_req(0, 1, 32'h0000_7000, 8'd0);
        grant(0);
        #1;
        check("final_ar_addr", m_araddr, 32'h0000_7000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_axi_rd_arbiter.md
# cache_axi_rd_arbiter

Two-master read-channel arbiter that shares the core's single AXI read port between the instruction cache and the data cache. It sits between the two caches' refill engines and the AXI AR/R channels of the bus interface.
- Accepts one burst read request at a time and owns the AR/R channels until the burst's last beat has been delivered.
- Uses round-robin grant on ties.
- Data-cache writes do not pass through this block.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width

Ports. Prefix i_ is the instruction-cache side, d_ the data-cache side, m_ the AXI side.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- i_arvalid / d_arvalid  in  1  burst read request
- i_araddr / d_araddr  in  ADDR_W  burst start address
- i_arlen / d_arlen  in  8  beats minus 1
- i_arsize / d_arsize  in  3  beat size code
- i_arburst / d_arburst  in  2  burst type
- i_arready / d_arready  out  1  request accepted (1-cycle pulse)
- i_rdata / d_rdata  out  DATA_W  routed read data
- i_rresp / d_rresp  out  2  routed response
- i_rvalid / d_rvalid  out  1  routed beat valid
- i_rlast / d_rlast  out  1  routed last beat
- i_rready / d_rready  in  1  requester can take beat
- m_arid  out  4  4'b0000 for I-side, 4'b0001 for D-side
- m_araddr  out  ADDR_W  registered request address
- m_arlen  out  8  registered request length
- m_arsize  out  3  registered request size
- m_arburst  out  2  registered request burst type
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  DATA_W  read data
- m_rresp  in  2  read response
- m_rvalid  in  1  read beat valid
- m_rlast  in  1  read last beat
- m_rready  out  1  read ready

## Operation
States: IDLE, I_AR, I_R, D_AR, D_R.

IDLE:
- Only i_arvalid set: grant I.
- Only d_arvalid set: grant D.
- Both set: grant the side that is not `last_grant`.
- On grant, in the same cycle:
  - pulse x_arready for the granted side;
  - latch x_araddr, x_arlen, x_arsize, x_arburst into the m_ar* registers;
  - set m_arid for the granted side;
  - set `last_grant`;
  - next state is X_AR.

X_AR:
- m_arvalid=1, m_ar* held stable.
- On m_arready=1, clear m_arvalid and go to X_R.

X_R:
- Combinational routing to the granted side only:
  - x_rdata=m_rdata, x_rresp=m_rresp, x_rvalid=m_rvalid, x_rlast=m_rlast;
  - m_rready=x_rready.
- The non-granted side's rvalid/rlast are 0; its rdata/rresp are 0.
- On m_rvalid & m_rready & m_rlast, go to IDLE.
- m_rlast without handshake (x_rready=0) does not leave the state.

General rules:
- `last_grant` is 1 bit and resets to D, so I wins the first tie.
- A requester keeps x_arvalid and payload stable until it sees x_arready.
- Requests arriving outside IDLE wait; x_arready stays 0 outside IDLE.
- m_rresp is routed unmodified; SLVERR/DECERR do not change sequencing.
- No flush input: an in-flight burst always completes, because AXI bursts cannot be aborted. Requesters discard unwanted data themselves.

## Timing
Reset (resetn=0 at clk edge):
- State goes to IDLE, `last_grant` goes to D.
- m_arvalid=0, m_araddr=0, m_arlen=0, m_arsize=3'b010, m_arburst=2'b01, m_arid=0.
- All x_arready, x_rvalid, x_rlast, x_rdata, x_rresp, m_rready outputs are 0.
- Reset mid-burst: immediate return to IDLE. The AXI slave is reset in the same domain.
- During reset, x_arready and routed outputs are 0 regardless of inputs.

Latency and throughput:
- A request seen in IDLE at cycle n gives x_arready=1 in cycle n and m_arvalid=1 from cycle n+1.
- m_arready in cycle k gives X_R from cycle k+1. Beats are routed with zero added latency.
- Last-beat handshake in cycle j gives IDLE in cycle j+1, so the next grant is at the earliest in j+1. There is one bubble between bursts.
- m_ar* outputs are registered. R-path outputs are combinational from m_r* and state.

## Test plan
- Single I request:
  - stimulus: addr 0x1FC0_0000, len 7, arready after 2 cycles, 8 beats;
  - response: m_arid=0 with m_arvalid held 3 cycles; i_rvalid for 8 beats; i_rlast on beat 8; IDLE next cycle; d_rvalid=0 throughout.
- Simultaneous I and D requests from reset:
  - response: I granted first (d_arready=0) and D granted in the cycle after I's rlast handshake;
  - a further tie then grants I, alternating.
- D request during an I burst:
  - response: d_arready stays 0 until I's rlast handshake, then pulses the next cycle;
  - m_araddr is unchanged during the I burst.
- Back-pressure:
  - stimulus: d_rready deasserted on beats 3-4 of a len-3 burst;
  - response: m_rready=0 on those cycles; data held, no beat lost; exit only after the last beat's handshake.
- Reset mid-burst:
  - stimulus: resetn=0 during D_R beat 2;
  - response: next cycle IDLE, all outputs at reset values; a new I request is granted first.
- Error response:
  - stimulus: m_rresp=2'b10 on a single-beat D read;
  - response: d_rresp=2'b10 with d_rlast=1; the arbiter returns to IDLE normally.
